// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b over WIDTH cycles, LSB first.
// One full-subtractor cell plus a registered borrow. The operands are latched
// on accept, so the operand bus is free while the result is being built.
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             bor;
  logic             x, y, d, bo, last;

  // Full-subtractor cell on the current LSBs and the carried borrow
  always_comb begin
    x    = a_sh[0];
    y    = b_sh[0];
    d    = x ^ y ^ bor;
    bo   = (~x & y) | (~(x ^ y) & bor);
    last = (cnt == CW'(WIDTH - 1));
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // State register; handshake outputs are registered copies of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  // Datapath: latch on accept, shift one bit per RUN cycle, publish on last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      bor    <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh <= a;
          b_sh <= b;
          bor  <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          res_sh <= {d, res_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          bor    <= bo;
          // Hold on the last bit so the counter never wraps inside an operation
          if (!last) cnt <= cnt + CW'(1);
          if (last) begin
            diff   <= {d, res_sh[WIDTH-1:1]};
            borrow <= bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH = 16).
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;

  int checks = 0;
  int passed = 0;
  logic [W:0] exp_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  // Present operands for one accept edge and record the expected result
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W-1:0] e;
    e = av - bv;
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back({(av < bv), e});
  endtask

  // Cycles from accept until out_valid (capped so a dead DUT cannot hang us)
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, borrow, diff} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL reset: got rdy=%b vld=%b bor=%b diff=%h want 1 0 0 0000",
               in_ready, out_valid, borrow, diff);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    logic [W:0] e;
    out_ready = 1'b1;
    start_op(16'h0005, 16'h0003);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 16) $display("FAIL basic_latency: got %0d want 16", lat);
    else passed++;
    checks++;
    if ({borrow, diff} !== e || e !== 17'h0_0002)
      $display("FAIL basic_result: got %b/%h want %b/%h", borrow, diff, e[W], e[W-1:0]);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL basic_handshake: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_underflow;
    logic [W-1:0] av[3] = '{16'h0003, 16'h0000, 16'hFFFF};
    logic [W-1:0] bv[3] = '{16'h0005, 16'h0001, 16'hFFFF};
    logic [W:0]   ref_v[3] = '{17'h1_FFFE, 17'h1_FFFF, 17'h0_0000};
    int lat;
    logic [W:0] e;
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i]);
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if ({borrow, diff} !== e || e !== ref_v[i] || lat !== 16)
        $display("FAIL underflow_%0d: got %b/%h lat %0d want %b/%h lat 16",
                 i, borrow, diff, lat, ref_v[i][W], ref_v[i][W-1:0]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [W:0] e;
    out_ready = 1'b0;
    start_op(16'h8000, 16'h0001);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if ({borrow, diff} !== e || e !== 17'h0_7FFF || lat !== 16)
      $display("FAIL bp_result: got %b/%h lat %0d want 0/7fff lat 16", borrow, diff, lat);
    else passed++;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, borrow, diff} !== {2'b10, e})
        $display("FAIL bp_hold_%0d: got vld=%b rdy=%b %b/%h", i, out_valid, in_ready, borrow, diff);
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_isolation;
    int lat;
    logic [W:0] e;
    a = 16'h1111; b = 16'h0222; in_valid = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 16'h0EEF});
    lat = 0;
    while (!out_valid && lat < 100) begin
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      lat++;
      checks++;
      if (!out_valid && in_ready !== 1'b0)
        $display("FAIL iso_busy_%0d: got rdy=%b want 0", lat, in_ready);
      else passed++;
    end
    e = exp_q.pop_front();
    checks++;
    if ({borrow, diff} !== e || lat !== 16)
      $display("FAIL iso_result: got %b/%h lat %0d want %b/%h lat 16",
               borrow, diff, lat, e[W], e[W-1:0]);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL iso_handshake: got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    logic [W:0] e;
    start_op(16'h1234, 16'h0FFF);
    void'(exp_q.pop_front());
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, borrow, diff} !== {1'b1, 1'b0, 1'b0, 16'h0000})
      $display("FAIL midrst: got rdy=%b vld=%b bor=%b diff=%h want 1 0 0 0000",
               in_ready, out_valid, borrow, diff);
    else passed++;
    #3 rst_n = 1'b1;
    start_op(16'h1234, 16'h0FFF);
    wait_done(lat);
    e = exp_q.pop_front();
    checks++;
    if ({borrow, diff} !== e || e !== 17'h0_0235 || lat !== 16)
      $display("FAIL midrst_rerun: got %b/%h lat %0d want 0/0235 lat 16", borrow, diff, lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_random;
    int lat, stall;
    logic [W:0] e;
    for (int n = 0; n < 1000; n++) begin
      stall = $urandom_range(0, 3);
      out_ready = (stall == 0);
      start_op(W'($urandom), W'($urandom));
      wait_done(lat);
      e = exp_q.pop_front();
      checks++;
      if ({borrow, diff} !== e || lat !== 16)
        $display("FAIL rand_%0d: got %b/%h lat %0d want %b/%h lat 16",
                 n, borrow, diff, lat, e[W], e[W-1:0]);
      else passed++;
      repeat (stall) @(posedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid} !== 2'b10)
        $display("FAIL rand_hs_%0d: got rdy=%b vld=%b want 1 0", n, in_ready, out_valid);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_backpressure();
    test_isolation();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
